// File: rtl/updown_count_decoder.sv
// updown_count_decoder: observes an up/down counter's output and recovers the
// command stream (load / step up / step down / hold) as registered events.
// Tracks the current direction run length and pulses on direction reversals.
// Optional build macro UPDOWN_DECODER_STATS_EN adds saturating 8-bit event
// counters n_up, n_down and n_load.
module updown_count_decoder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RUN_W = 8
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic [WIDTH-1:0] O_in,
  input  logic             sample_en,
  output logic             evt_valid,
  output logic             evt_load,
  output logic             evt_count,
  output logic             evt_up_down,
  output logic [WIDTH-1:0] evt_value,
  output logic             reversal,
  output logic [RUN_W-1:0] run_len,
  output logic [1:0]       dir_state
`ifdef UPDOWN_DECODER_STATS_EN
  ,
  output logic [7:0]       n_up,
  output logic [7:0]       n_down,
  output logic [7:0]       n_load
`endif
);

  localparam logic [1:0] StNoSync = 2'b00;
  localparam logic [1:0] StHold   = 2'b01;
  localparam logic [1:0] StUp     = 2'b10;
  localparam logic [1:0] StDown   = 2'b11;

  localparam logic [WIDTH-1:0] DiffOne     = WIDTH'(1);
  localparam logic [WIDTH-1:0] DiffAllOnes = {WIDTH{1'b1}};
  localparam logic [RUN_W-1:0] RunOne      = RUN_W'(1);
  localparam logic [RUN_W-1:0] RunMax      = {RUN_W{1'b1}};

  logic [WIDTH-1:0] prev_value_q, prev_value_d;
  logic             prev_valid_q, prev_valid_d;
  logic [1:0]       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             valid_q, valid_d;
  logic             load_q, load_d;
  logic             count_q, count_d;
  logic             up_down_q, up_down_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             rev_q, rev_d;

  logic [WIDTH-1:0] diff;
  logic             is_up, is_down, is_hold;
  logic [RUN_W-1:0] run_inc;

  // Classify the step between the stored reference and the new sample.
  always_comb begin
    diff    = O_in - prev_value_q;
    is_up   = (diff == DiffOne);
    // Up wins when WIDTH==1 makes +1 and -1 the same difference.
    is_down = !is_up && (diff == DiffAllOnes);
    is_hold = (diff == '0);
    run_inc = (run_q == RunMax) ? run_q : run_q + RunOne;
  end

  // Next-state: direction FSM, run length and event flags.
  always_comb begin
    prev_value_d = prev_value_q;
    prev_valid_d = prev_valid_q;
    state_d      = state_q;
    run_d        = run_q;
    valid_d      = 1'b0;
    rev_d        = 1'b0;
    load_d       = load_q;
    count_d      = count_q;
    up_down_d    = up_down_q;
    value_d      = value_q;
    // Disabled samples freeze everything except the two pulses.
    if (sample_en) begin
      load_d       = 1'b0;
      count_d      = 1'b0;
      up_down_d    = 1'b0;
      prev_value_d = O_in;
      prev_valid_d = 1'b1;
      if (!prev_valid_q) begin
        state_d = StHold;
      end else if (is_up) begin
        valid_d = 1'b1;
        count_d = 1'b1;
        value_d = O_in;
        state_d = StUp;
        run_d   = (state_q == StUp) ? run_inc : RunOne;
        rev_d   = (state_q == StDown);
      end else if (is_down) begin
        valid_d   = 1'b1;
        count_d   = 1'b1;
        up_down_d = 1'b1;
        value_d   = O_in;
        state_d   = StDown;
        run_d     = (state_q == StDown) ? run_inc : RunOne;
        rev_d     = (state_q == StUp);
      end else if (!is_hold) begin
        valid_d = 1'b1;
        load_d  = 1'b1;
        value_d = O_in;
        state_d = StHold;
        run_d   = '0;
      end
      // A hold keeps state and run length untouched.
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      prev_value_q <= '0;
      prev_valid_q <= 1'b0;
      state_q      <= StNoSync;
      run_q        <= '0;
      valid_q      <= 1'b0;
      load_q       <= 1'b0;
      count_q      <= 1'b0;
      up_down_q    <= 1'b0;
      value_q      <= '0;
      rev_q        <= 1'b0;
    end else begin
      prev_value_q <= prev_value_d;
      prev_valid_q <= prev_valid_d;
      state_q      <= state_d;
      run_q        <= run_d;
      valid_q      <= valid_d;
      load_q       <= load_d;
      count_q      <= count_d;
      up_down_q    <= up_down_d;
      value_q      <= value_d;
      rev_q        <= rev_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_load    = load_q;
  assign evt_count   = count_q;
  assign evt_up_down = up_down_q;
  assign evt_value   = value_q;
  assign reversal    = rev_q;
  assign run_len     = run_q;
  assign dir_state   = state_q;

`ifdef UPDOWN_DECODER_STATS_EN
  logic [7:0] n_up_q, n_up_d;
  logic [7:0] n_down_q, n_down_d;
  logic [7:0] n_load_q, n_load_d;

  // Saturating per-kind event counters, updated alongside the event registers.
  always_comb begin
    n_up_d   = n_up_q;
    n_down_d = n_down_q;
    n_load_d = n_load_q;
    if (valid_d && count_d && !up_down_d && (n_up_q != 8'hff)) begin
      n_up_d = n_up_q + 8'd1;
    end
    if (valid_d && count_d && up_down_d && (n_down_q != 8'hff)) begin
      n_down_d = n_down_q + 8'd1;
    end
    if (valid_d && load_d && (n_load_q != 8'hff)) begin
      n_load_d = n_load_q + 8'd1;
    end
  end

  // Counter registers share the block's synchronous reset.
  always_ff @(posedge clk) begin
    if (!sync_reset) begin
      n_up_q   <= '0;
      n_down_q <= '0;
      n_load_q <= '0;
    end else begin
      n_up_q   <= n_up_d;
      n_down_q <= n_down_d;
      n_load_q <= n_load_d;
    end
  end

  assign n_up   = n_up_q;
  assign n_down = n_down_q;
  assign n_load = n_load_q;
`endif

endmodule

// File: tb/tb_updown_count_decoder.sv
// Self-checking bench for updown_count_decoder: a hand-computed vector table,
// a 300-step saturation sequence and randomized traffic against a model.
module tb_updown_count_decoder;

  localparam int W  = 4;
  localparam int RW = 8;
  localparam int VMOD   = 1 << W;
  localparam int RUNMAX = (1 << RW) - 1;

  logic          clk = 1'b0;
  logic          sync_reset;
  logic          sample_en;
  logic [W-1:0]  O_in;
  logic          evt_valid, evt_load, evt_count, evt_up_down, reversal;
  logic [W-1:0]  evt_value;
  logic [RW-1:0] run_len;
  logic [1:0]    dir_state;
`ifdef UPDOWN_DECODER_STATS_EN
  logic [7:0]    n_up, n_down, n_load;
`endif

  always #5 clk = ~clk;

  updown_count_decoder #(.WIDTH(W), .RUN_W(RW)) dut (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .O_in        (O_in),
    .sample_en   (sample_en),
    .evt_valid   (evt_valid),
    .evt_load    (evt_load),
    .evt_count   (evt_count),
    .evt_up_down (evt_up_down),
    .evt_value   (evt_value),
    .reversal    (reversal),
    .run_len     (run_len),
    .dir_state   (dir_state)
`ifdef UPDOWN_DECODER_STATS_EN
    ,
    .n_up        (n_up),
    .n_down      (n_down),
    .n_load      (n_load)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int v, input int l, input int c,
                         input int ud, input int value, input int rev, input int run,
                         input int st);
    chk({tag, ".evt_valid"},   32'(evt_valid),   v);
    chk({tag, ".evt_load"},    32'(evt_load),    l);
    chk({tag, ".evt_count"},   32'(evt_count),   c);
    chk({tag, ".evt_up_down"}, 32'(evt_up_down), ud);
    chk({tag, ".evt_value"},   32'(evt_value),   value);
    chk({tag, ".reversal"},    32'(reversal),    rev);
    chk({tag, ".run_len"},     32'(run_len),     run);
    chk({tag, ".dir_state"},   32'(dir_state),   st);
  endtask

  // Reference model: direction as -1/0/+1, values as plain integers.
  bit m_sync;
  int m_prev, m_dir, m_run;
  int m_v, m_l, m_c, m_ud, m_value, m_rev;
  int m_nu, m_nd, m_nl;

  function automatic int sat8(input int x);
    return (x >= 255) ? 255 : x + 1;
  endfunction

  function automatic void model(input bit rst_n, input bit en, input int val);
    int d;
    int stp;
    if (!rst_n) begin
      m_sync = 0; m_prev = 0; m_dir = 0; m_run = 0;
      m_v = 0; m_l = 0; m_c = 0; m_ud = 0; m_value = 0; m_rev = 0;
      m_nu = 0; m_nd = 0; m_nl = 0;
      return;
    end
    m_v = 0;
    m_rev = 0;
    if (!en) return;
    m_l = 0; m_c = 0; m_ud = 0;
    if (!m_sync) begin
      m_sync = 1;
      m_dir = 0;
    end else begin
      d = (val - m_prev + VMOD) % VMOD;
      stp = (d == 1) ? 1 : (d == VMOD - 1) ? -1 : 0;
      if (stp != 0) begin
        m_v = 1; m_c = 1; m_ud = (stp < 0); m_value = val;
        m_rev = (m_dir == -stp);
        m_run = (m_dir == stp) ? ((m_run >= RUNMAX) ? RUNMAX : m_run + 1) : 1;
        m_dir = stp;
        if (stp > 0) m_nu = sat8(m_nu); else m_nd = sat8(m_nd);
      end else if (d != 0) begin
        m_v = 1; m_l = 1; m_value = val; m_run = 0; m_dir = 0;
        m_nl = sat8(m_nl);
      end
    end
    m_prev = val;
  endfunction

  function automatic int m_state();
    if (!m_sync) return 0;
    if (m_dir == 0) return 1;
    return (m_dir > 0) ? 2 : 3;
  endfunction

  task automatic apply(input bit rst_n, input bit en, input int val);
    sync_reset = rst_n;
    sample_en  = en;
    O_in       = W'(val);
    @(posedge clk);
    #1;
    model(rst_n, en, val);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_v, m_l, m_c, m_ud, m_value, m_rev, m_run, m_state());
`ifdef UPDOWN_DECODER_STATS_EN
    chk({tag, ".n_up"},   32'(n_up),   m_nu);
    chk({tag, ".n_down"}, 32'(n_down), m_nd);
    chk({tag, ".n_load"}, 32'(n_load), m_nl);
`endif
  endtask

  typedef struct {
    bit rst_n; bit en; int val;
    int v; int l; int c; int ud; int value; int rev; int run; int st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit rst_n, input bit en, input int val, input int v,
                              input int l, input int c, input int ud, input int value,
                              input int rev, input int run, input int st);
    vec_t e;
    e.rst_n = rst_n; e.en = en; e.val = val; e.v = v; e.l = l; e.c = c; e.ud = ud;
    e.value = value; e.rev = rev; e.run = run; e.st = st;
    tbl.push_back(e);
  endfunction

  initial begin
    int val;
    int r;
    sync_reset = 1'b0;
    sample_en  = 1'b0;
    O_in       = '0;

    //  rst en val | v  l  c  ud value rev run st
    add(0, 0, 0,    0, 0, 0, 0, 0,  0, 0, 0);
    add(0, 1, 0,    0, 0, 0, 0, 0,  0, 0, 0);
    add(1, 1, 0,    0, 0, 0, 0, 0,  0, 0, 1);  // sync, no event
    add(0, 1, 5,    0, 0, 0, 0, 0,  0, 0, 0);  // reset again
    add(1, 1, 5,    0, 0, 0, 0, 0,  0, 0, 1);
    add(1, 1, 6,    1, 0, 1, 0, 6,  0, 1, 2);
    add(1, 1, 7,    1, 0, 1, 0, 7,  0, 2, 2);
    add(1, 1, 8,    1, 0, 1, 0, 8,  0, 3, 2);
    add(1, 1, 9,    1, 0, 1, 0, 9,  0, 4, 2);
    add(1, 1, 8,    1, 0, 1, 1, 8,  1, 1, 3);  // reversal
    add(1, 1, 7,    1, 0, 1, 1, 7,  0, 2, 3);
    add(1, 1, 7,    0, 0, 0, 0, 7,  0, 2, 3);  // hold keeps run
    add(1, 1, 14,   1, 1, 0, 0, 14, 0, 0, 1);  // load
    add(1, 1, 15,   1, 0, 1, 0, 15, 0, 1, 2);
    add(1, 1, 0,    1, 0, 1, 0, 0,  0, 2, 2);  // wrap up
    add(1, 1, 1,    1, 0, 1, 0, 1,  0, 3, 2);
    add(1, 1, 0,    1, 0, 1, 1, 0,  1, 1, 3);  // reversal
    add(1, 1, 15,   1, 0, 1, 1, 15, 0, 2, 3);  // wrap down
    add(1, 1, 5,    1, 1, 0, 0, 5,  0, 0, 1);
    add(1, 1, 9,    1, 1, 0, 0, 9,  0, 0, 1);
    add(1, 1, 9,    0, 0, 0, 0, 9,  0, 0, 1);
    add(1, 0, 3,    0, 0, 0, 0, 9,  0, 0, 1);  // disabled: frozen
    add(1, 0, 12,   0, 0, 0, 0, 9,  0, 0, 1);
    add(1, 0, 1,    0, 0, 0, 0, 9,  0, 0, 1);
    add(1, 1, 10,   1, 0, 1, 0, 10, 0, 1, 2);  // step relative to 9
    add(0, 1, 11,   0, 0, 0, 0, 0,  0, 0, 0);  // reset mid-run

    foreach (tbl[i]) begin
      apply(tbl[i].rst_n, tbl[i].en, tbl[i].val);
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].ud,
              tbl[i].value, tbl[i].rev, tbl[i].run, tbl[i].st);
    end

    // 300 consecutive up steps: run length (and n_up) saturate.
    apply(0, 0, 0);
    apply(1, 1, 0);
    for (int i = 1; i <= 300; i++) begin
      apply(1, 1, i % VMOD);
      chk_model($sformatf("sat%0d", i));
    end
    chk("sat.run_len_final", 32'(run_len), RUNMAX);
`ifdef UPDOWN_DECODER_STATS_EN
    chk("sat.n_up_final",   32'(n_up),   255);
    chk("sat.n_down_final", 32'(n_down), 0);
    chk("sat.n_load_final", 32'(n_load), 0);
`endif
    apply(0, 1, 3);
    chk("midreset.dir_state", 32'(dir_state), 0);
    chk("midreset.run_len",   32'(run_len),   0);
`ifdef UPDOWN_DECODER_STATS_EN
    chk("midreset.n_up", 32'(n_up), 0);
`endif

    // Randomized traffic biased toward steps so runs and reversals occur.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40)      val = (m_prev + 1) % VMOD;
      else if (r < 70) val = (m_prev + VMOD - 1) % VMOD;
      else if (r < 80) val = m_prev;
      else             val = int'($urandom_range(0, VMOD - 1));
      apply(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 85), val);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_count_decoder.md
Name: updown_count_decoder

Overview:
- Receive-side companion to the team's binary up/down counter.
- Watches the counter's output value every cycle and recovers the command stream that produced it: load with value, count up, count down, or hold.
- Outputs a registered event stream for monitoring and self-checking logic in the CORDIC datapath. It also tracks the current direction run and flags direction reversals.

Parameters:
- WIDTH, 4, bit width of observed counter value.
- RUN_W, 8, width of the saturating same-direction run-length counter.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- sync_reset  input  1  reset, synchronous and active-low; sampled only on rising clk.
- O_in  input  WIDTH  counter output value being observed.
- sample_en  input  1  qualifies O_in; when 0 the sample is ignored and no state changes.
- evt_valid  output  1  one-cycle pulse: a decoded event is presented this cycle.
- evt_load  output  1  event is a load (non-unit jump).
- evt_count  output  1  event is a unit step (up or down).
- evt_up_down  output  1  step direction: 1 = down, 0 = up (matches counter's up_down sense); 0 for load or hold.
- evt_value  output  WIDTH  the new observed value belonging to the event.
- reversal  output  1  one-cycle pulse: step direction opposite to the previous step run.
- run_len  output  RUN_W  consecutive steps in the current direction, saturating at all-ones.
- dir_state  output  2  FSM state: 00 NOSYNC, 01 HOLD, 10 UP, 11 DOWN.

Behaviour:
- Reset (sync_reset==0 at an edge):
  - All outputs go to 0.
  - dir_state = NOSYNC.
  - Internal prev_value = 0; prev_valid = 0.
- Latency: decode is combinational on (prev_value, O_in). All outputs are registered and appear the cycle after the qualifying sample.
- First qualified sample after reset (NOSYNC):
  - Store the value and go to HOLD.
  - evt_valid = 0, because there is no prior reference.
- Classification for each qualified sample with prior reference, let d = O_in - prev_value mod 2^WIDTH:
  - d==0: hold. evt_valid = 0. State is unchanged, except UP/DOWN go to HOLD only if RUN_HOLD_BREAK (fixed rule: a hold does NOT break the run; state and run_len are kept).
  - d==1: up step. Wrap from all-ones to 0 counts as up. Sets evt_valid = 1, evt_count = 1, evt_up_down = 0. Next state UP.
  - d==all-ones (−1): down step. Wrap from 0 to all-ones counts as down. Sets evt_valid = 1, evt_count = 1, evt_up_down = 1. Next state DOWN.
  - Any other d: load. Sets evt_valid = 1, evt_load = 1. Next state HOLD; run_len cleared to 0.
- run_len:
  - A step in the same direction as the current state increments it, saturating.
  - A step from HOLD sets it to 1.
  - A step opposite to the current UP/DOWN sets it to 1 and pulses reversal = 1.
- Flags not asserted by the current event are driven 0 each cycle. evt_value = O_in whenever evt_valid = 1, otherwise it holds its last value.
- sample_en = 0: no classification. Pulses (evt_valid, reversal) return to 0. All other state is frozen.
- WIDTH==1: d==1 and d==−1 coincide. That case is classified as an up step (up has priority).
- Reset asserted mid-run has priority over sample_en and returns the block to NOSYNC on that edge.

Optional Feature:
- Macro: UPDOWN_DECODER_STATS_EN.
- Defined:
  - Adds three output ports: n_up, n_down and n_load, each 8 bits.
  - Each is a saturating counter of the decoded events of its kind.
  - All three are cleared by reset.
  - All three update in the same cycle as evt_valid.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset held 2 cycles, then sample 0 -> all outputs 0, dir_state NOSYNC then HOLD, evt_valid never pulses.
- Samples 5,6,7,8 after sync -> three pulses with evt_count=1, evt_up_down=0, evt_value 6,7,8; run_len 1,2,3; dir_state UP.
- Samples 9,8,7 following an up run -> first event has reversal=1 and run_len=1; second has run_len=2; dir_state DOWN.
- Samples 14,15,0,1 (up) then 0,15 (down) -> wrap steps decode as up then down. Only one reversal, at 1->0.
- Samples 5 then 9 -> evt_load=1, evt_value=9, run_len 0, dir_state HOLD. Sample_en low for 3 cycles with O_in toggling -> no events, state frozen.
- With UPDOWN_DECODER_STATS_EN: 300 up steps -> n_up saturates at 255; n_down=0, n_load=0. Reset mid-run -> counters cleared and NOSYNC.
